// File: rtl/sm4_key_expand.sv
// SM4 key schedule: expands a 128-bit master key into 32 round keys,
// one per cycle, into a combinationally readable round-key table.
module sm4_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] TBL = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  // Entry 0 sits in the most significant byte.
  logic [10:0] idx;
  assign idx = {~a, 3'b000};
  assign y   = TBL[idx +: 8];
endmodule

module sm4_key_expand (
  input  logic         clk_sys,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_start,
  output logic [4:0]   sm4_round_cnt,
  input  logic [31:0]  sm4_key_cki,
  output logic         key_busy,
  output logic         key_done,
  output logic         rk_table_valid,
  output logic         rk_wr_en,
  output logic [4:0]   rk_wr_idx,
  output logic [31:0]  rk_wr_data,
  input  logic [4:0]   rk_rd_addr,
  output logic [31:0]  rk_rd_data
);
  typedef enum logic [1:0] {
    IDLE, INIT, RUN, DONE
  } state_e;

  localparam logic [127:0] FK =
    128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [31:0] k_q [4];
  logic [31:0] k_d [4];
  logic [31:0] tbl_q [32];
  logic [31:0] tbl_d [32];
  logic [31:0] b, tau, rk;

  assign b = k_q[1] ^ k_q[2] ^ k_q[3] ^ sm4_key_cki;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sm4_sbox u_sbox (
      .a (b[8*g +: 8]),
      .y (tau[8*g +: 8])
    );
  end

  assign rk = k_q[0] ^ tau
            ^ {tau[18:0], tau[31:19]}
            ^ {tau[8:0], tau[31:9]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    k_d     = k_q;
    tbl_d   = tbl_q;
    unique case (state_q)
      IDLE: begin
        if (key_start) begin
          state_d = INIT;
          cnt_d   = '0;
          valid_d = 1'b0;
          for (int j = 0; j < 4; j++) begin
            k_d[j] = key_in[127-32*j -: 32]
                   ^ FK[127-32*j -: 32];
          end
        end
      end
      INIT: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        tbl_d[cnt_q] = rk;
        k_d[0] = k_q[1];
        k_d[1] = k_q[2];
        k_d[2] = k_q[3];
        k_d[3] = rk;
        // Natural 5-bit wrap returns the CK address to 0.
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = DONE;
      end
      DONE: begin
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      for (int j = 0; j < 4; j++) k_q[j] <= '0;
      for (int i = 0; i < 32; i++) tbl_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      k_q     <= k_d;
      tbl_q   <= tbl_d;
    end
  end

  assign sm4_round_cnt  = cnt_q;
  assign key_busy       = (state_q == INIT) || (state_q == RUN);
  assign key_done       = (state_q == DONE);
  assign rk_table_valid = valid_q;
  assign rk_wr_en       = (state_q == RUN);
  assign rk_wr_idx      = cnt_q;
  assign rk_wr_data     = rk_wr_en ? rk : '0;
  assign rk_rd_data     = tbl_q[rk_rd_addr];
endmodule

// File: tb/tb_sm4_key_expand.sv
// Directed bench for sm4_key_expand with a behavioural CK lookup
// and an independent SM4 key-schedule reference model.
module tb_sm4_key_expand;
  logic         clk_sys = 1'b0;
  logic         rst_n;
  logic [127:0] key_in;
  logic         key_start;
  logic [4:0]   sm4_round_cnt;
  logic [31:0]  sm4_key_cki;
  logic         key_busy, key_done, rk_table_valid, rk_wr_en;
  logic [4:0]   rk_wr_idx, rk_rd_addr;
  logic [31:0]  rk_wr_data, rk_rd_data;

  sm4_key_expand dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .key_in(key_in),
    .key_start(key_start), .sm4_round_cnt(sm4_round_cnt),
    .sm4_key_cki(sm4_key_cki), .key_busy(key_busy),
    .key_done(key_done), .rk_table_valid(rk_table_valid),
    .rk_wr_en(rk_wr_en), .rk_wr_idx(rk_wr_idx),
    .rk_wr_data(rk_wr_data), .rk_rd_addr(rk_rd_addr),
    .rk_rd_data(rk_rd_data)
  );

  always #5 clk_sys = ~clk_sys;

  localparam logic [2047:0] SB = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  localparam logic [127:0] GBT =
    128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] KEY_A =
    128'h00112233445566778899AABBCCDDEEFF;

  function automatic logic [7:0] sb(input logic [7:0] a);
    return SB[2047 - 8*int'(a) -: 8];
  endfunction

  // CK_i byte j = (4i+j)*7 mod 256
  function automatic logic [31:0] ck(input logic [4:0] i);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      r = {r[23:0], 8'((4 * int'(i) + j) * 7)};
    end
    return r;
  endfunction

  assign sm4_key_cki = ck(sm4_round_cnt);

  logic [31:0] mrk [32];

  task automatic run_model(input logic [127:0] mk);
    logic [31:0] fk [4];
    logic [31:0] k [36];
    logic [31:0] t, s;
    fk = '{32'hA3B1BAC6, 32'h56AA3350,
           32'h677D9197, 32'hB27022DC};
    for (int j = 0; j < 4; j++)
      k[j] = mk[127-32*j -: 32] ^ fk[j];
    for (int i = 0; i < 32; i++) begin
      t = k[i+1] ^ k[i+2] ^ k[i+3] ^ ck(5'(i));
      s = {sb(t[31:24]), sb(t[23:16]),
           sb(t[15:8]), sb(t[7:0])};
      k[i+4] = k[i] ^ s ^ ((s << 13) | (s >> 19))
             ^ ((s << 23) | (s >> 9));
      mrk[i] = k[i+4];
    end
  endtask

  typedef struct {
    int          phase;
    logic [4:0]  addr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [5];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic apply_vecs(input int phase);
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].phase == phase) begin
        rk_rd_addr = vecs[v].addr;
        #1;
        chk("vec_rd", rk_rd_data, vecs[v].exp);
      end
    end
  endtask

  // Starts at the next edge; returns in the cycle after key_done.
  task automatic expand(input logic [127:0] k, input bit inject);
    run_model(k);
    key_in = k;
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
    chk("valid_drop", 32'(rk_table_valid), 32'd0);
    for (int c = 1; c <= 34; c++) begin
      chk("key_done", 32'(key_done), 32'(c == 34));
      chk("key_busy", 32'(key_busy), 32'(c <= 33));
      chk("wr_en", 32'(rk_wr_en), 32'(c >= 2 && c <= 33));
      if (c >= 2 && c <= 33) begin
        chk("round_cnt", 32'(sm4_round_cnt), 32'(c - 2));
        chk("wr_idx", 32'(rk_wr_idx), 32'(c - 2));
        chk("wr_data", rk_wr_data, mrk[c-2]);
      end else begin
        chk("round_cnt_idle", 32'(sm4_round_cnt), 32'd0);
      end
      if (inject && (c == 5 || c == 33)) begin
        key_in = ~k;
        key_start = 1'b1;
      end
      tick();
      key_start = 1'b0;
      key_in = k;
    end
    chk("done_once", 32'(key_done), 32'd0);
    chk("no_restart", 32'(key_busy), 32'd0);
    chk("valid_set", 32'(rk_table_valid), 32'd1);
    chk("cnt_after", 32'(sm4_round_cnt), 32'd0);
    for (int a = 0; a < 32; a++) begin
      rk_rd_addr = 5'(a);
      #1;
      chk("table", rk_rd_data, mrk[a]);
    end
  endtask

  initial begin
    int ndone;
    run_model('0);
    vecs[0] = '{0, 5'd0,  32'hF12186F9};
    vecs[1] = '{0, 5'd1,  32'h41662B61};
    vecs[2] = '{0, 5'd31, 32'h9124A012};
    vecs[3] = '{2, 5'd0,  mrk[0]};
    vecs[4] = '{2, 5'd31, mrk[31]};

    rst_n = 1'b0;
    key_start = 1'b0;
    key_in = '0;
    rk_rd_addr = '0;
    repeat (3) tick();
    chk("rst_cnt", 32'(sm4_round_cnt), 32'd0);
    chk("rst_busy", 32'(key_busy), 32'd0);
    chk("rst_done", 32'(key_done), 32'd0);
    chk("rst_valid", 32'(rk_table_valid), 32'd0);
    chk("rst_wr_en", 32'(rk_wr_en), 32'd0);
    chk("rst_wr_idx", 32'(rk_wr_idx), 32'd0);
    chk("rst_wr_data", rk_wr_data, 32'd0);
    for (int a = 0; a < 32; a++) begin
      rk_rd_addr = 5'(a);
      #1;
      chk("rst_table", rk_rd_data, 32'd0);
    end
    rst_n = 1'b1;
    tick();

    expand(GBT, 1'b0);
    apply_vecs(0);
    tick();

    expand(KEY_A, 1'b1);
    expand('0, 1'b0);
    apply_vecs(2);
    tick();

    key_in = GBT;
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
    repeat (19) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_busy", 32'(key_busy), 32'd0);
    chk("mid_rst_valid", 32'(rk_table_valid), 32'd0);
    chk("mid_rst_cnt", 32'(sm4_round_cnt), 32'd0);
    rk_rd_addr = 5'd0;
    #1;
    chk("mid_rst_table", rk_rd_data, 32'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      ndone += int'(key_done);
      tick();
    end
    chk("mid_rst_no_done", 32'(ndone), 32'd0);
    chk("mid_rst_valid2", 32'(rk_table_valid), 32'd0);

    expand(GBT, 1'b0);
    apply_vecs(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
